// File: rtl/fb_write_ctrl.sv
// Frame-buffer write controller: window cursor, pixel FIFO, SRAM req/ack port, full-screen clear.
// Optional clipping of off-screen pixels when FBW_CLIP_EN is defined.
module fb_write_ctrl #(
  parameter int H_ACTIVE   = 160,
  parameter int V_ACTIVE   = 128,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_pixel_data,
  input  logic [31:0]       i_col_addr,
  input  logic [31:0]       i_row_addr,
  input  logic              i_clr_req,
  input  logic              i_write_req,
  input  logic              i_waddr_set_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic              o_mem_wreq,
  input  logic              i_mem_wack,
  output logic              o_busy,
  output logic              o_fifo_ovf
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, CLEAR} state_e;
  state_e state_q, state_d;

  logic [15:0] xs_q, xe_q, ys_q, ye_q, x_q, y_q;
  logic [15:0] xs_d, xe_d, ys_d, ye_d, x_d, y_d;
  logic [15:0] px, py;

  logic [ADDR_W-1:0] fa_q [FIFO_DEPTH];
  logic [15:0]       fd_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [15:0]       mdata_q, mdata_d;
  logic              wreq_q, wreq_d, ovf_q, ovf_d, restart_q, restart_d;

  logic              wr_acc, in_win, push_try, push, pop, full;
  logic [ADDR_W-1:0] push_addr;

  // Window latch first, so a same-cycle pixel lands on the new origin and advances from it.
  always_comb begin
    xs_d = xs_q; xe_d = xe_q; ys_d = ys_q; ye_d = ye_q;
    x_d  = x_q;  y_d  = y_q;
    if (i_waddr_set_req) begin
      xs_d = i_col_addr[31:16];
      xe_d = (i_col_addr[15:0] < i_col_addr[31:16]) ? i_col_addr[31:16] : i_col_addr[15:0];
      ys_d = i_row_addr[31:16];
      ye_d = (i_row_addr[15:0] < i_row_addr[31:16]) ? i_row_addr[31:16] : i_row_addr[15:0];
      x_d  = xs_d;
      y_d  = ys_d;
    end
    px     = x_d;
    py     = y_d;
    wr_acc = i_write_req && (state_q == IDLE);
    if (wr_acc) begin
      if (x_d == xe_d) begin
        x_d = xs_d;
        y_d = (y_d == ye_d) ? ys_d : y_d + 16'd1;
      end else begin
        x_d = x_d + 16'd1;
      end
    end
  end

  // Modular arithmetic: truncating operands to ADDR_W gives the truncated full product.
  assign push_addr = ADDR_W'(py) * ADDR_W'(H_ACTIVE) + ADDR_W'(px);

`ifdef FBW_CLIP_EN
  assign in_win = (32'(px) < 32'(H_ACTIVE)) && (32'(py) < 32'(V_ACTIVE));
`else
  assign in_win = 1'b1;
`endif

  assign push_try = wr_acc && in_win;
  assign pop      = (state_q == IDLE) && wreq_q && i_mem_wack;
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign push     = push_try && (!full || pop);

  always_comb begin
    state_d   = state_q;
    rd_d      = pop  ? rd_q + PW'(1) : rd_q;
    wr_d      = push ? wr_q + PW'(1) : wr_q;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    maddr_d   = maddr_q;
    mdata_d   = mdata_q;
    wreq_d    = wreq_q;
    ovf_d     = ovf_q | (push_try && full && !pop);
    restart_d = restart_q;
    case (state_q)
      IDLE: begin
        // No new entry is presented once a clear is requested; only the in-flight one finishes.
        if (pop) begin
          if (cnt_q > CW'(1) && !i_clr_req) begin
            maddr_d = fa_q[rd_q + PW'(1)];
            mdata_d = fd_q[rd_q + PW'(1)];
            wreq_d  = 1'b1;
          end else begin
            wreq_d  = 1'b0;
          end
        end else if (!wreq_q && cnt_q != '0 && !i_clr_req) begin
          maddr_d = fa_q[rd_q];
          mdata_d = fd_q[rd_q];
          wreq_d  = 1'b1;
        end
        if (i_clr_req) state_d = FLUSH;
      end
      FLUSH: begin
        if (!wreq_q || i_mem_wack) begin
          wreq_d    = 1'b0;
          rd_d      = '0;
          wr_d      = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          restart_d = 1'b0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        if (i_clr_req) restart_d = 1'b1;
        if (!wreq_q) begin
          maddr_d   = '0;
          mdata_d   = '0;
          wreq_d    = 1'b1;
          restart_d = 1'b0;
        end else if (i_mem_wack) begin
          if (restart_q || i_clr_req) begin
            maddr_d   = '0;
            restart_d = 1'b0;
          end else if (maddr_q == LAST_ADDR) begin
            wreq_d  = 1'b0;
            state_d = IDLE;
          end else begin
            maddr_d = maddr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      xs_q      <= '0; xe_q <= '0; ys_q <= '0; ye_q <= '0;
      x_q       <= '0; y_q  <= '0;
      rd_q      <= '0; wr_q <= '0; cnt_q <= '0;
      maddr_q   <= '0; mdata_q <= '0;
      wreq_q    <= 1'b0; ovf_q <= 1'b0; restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      xs_q      <= xs_d; xe_q <= xe_d; ys_q <= ys_d; ye_q <= ye_d;
      x_q       <= x_d;  y_q  <= y_d;
      rd_q      <= rd_d; wr_q <= wr_d; cnt_q <= cnt_d;
      maddr_q   <= maddr_d; mdata_q <= mdata_d;
      wreq_q    <= wreq_d; ovf_q <= ovf_d; restart_q <= restart_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fa_q[wr_q] <= push_addr;
      fd_q[wr_q] <= i_pixel_data;
    end
  end

  assign o_mem_addr  = maddr_q;
  assign o_mem_wdata = mdata_q;
  assign o_mem_wreq  = wreq_q;
  assign o_fifo_ovf  = ovf_q;
  assign o_busy      = (state_q != IDLE) || (cnt_q != '0) || wreq_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Bench for fb_write_ctrl: cursor/address model with expected-write queue vs. observed SRAM writes.
module tb_fb_write_ctrl;
  localparam int H = 160, V = 128, AW = 15, DEPTH = 4;

  logic          clk, rst_n;
  logic [15:0]   data;
  logic [31:0]   col, row;
  logic          clr, wr, setw, wack;
  logic [AW-1:0] maddr;
  logic [15:0]   mdata;
  logic          wreq, busy, ovf;

  fb_write_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_data(data), .i_col_addr(col), .i_row_addr(row),
    .i_clr_req(clr), .i_write_req(wr), .i_waddr_set_req(setw),
    .o_mem_addr(maddr), .o_mem_wdata(mdata), .o_mem_wreq(wreq), .i_mem_wack(wack),
    .o_busy(busy), .o_fifo_ovf(ovf));

  initial begin clk = 0; forever #5 clk = ~clk; end

  int checks = 0, passes = 0;
  bit rand_ack = 0;
  logic [AW+15:0] got[$], exp[$];
  int wxs, wxe, wys, wye, cx, cy;

  always @(negedge clk)
    if (rst_n && wreq && wack) got.push_back({maddr, mdata});

  task automatic step();
    @(posedge clk); #1;
    wr = 0; setw = 0; clr = 0;
    if (rand_ack) wack = 1'($urandom_range(0, 1));
  endtask

  task automatic model_reset();
    wxs = 0; wxe = 0; wys = 0; wye = 0; cx = 0; cy = 0;
  endtask

  task automatic set_win(input int xs, input int xe, input int ys, input int ye);
    col = {16'(xs), 16'(xe)}; row = {16'(ys), 16'(ye)}; setw = 1;
    wxs = xs; wxe = (xe < xs) ? xs : xe; wys = ys; wye = (ye < ys) ? ys : ye;
    cx = xs; cy = ys;
  endtask

  // room=0 marks a pixel the FIFO cannot take: cursor still moves, nothing is expected.
  task automatic do_write(input logic [15:0] d, input bit room);
    int a;
    bit inw;
    wr = 1; data = d;
    a = (cy * H + cx) % (1 << AW);
`ifdef FBW_CLIP_EN
    inw = (cx < H) && (cy < V);
`else
    inw = 1;
`endif
    if (room && inw) exp.push_back({AW'(a), d});
    if (cx == wxe) begin cx = wxs; cy = (cy == wye) ? wys : cy + 1; end
    else cx = cx + 1;
  endtask

  task automatic wait_idle(output bit ok, input int bound);
    ok = 0;
    for (int n = 0; n < bound; n++) begin
      step(); @(negedge clk);
      if (!busy) begin ok = 1; return; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({maddr, mdata, wreq, busy, ovf} !== '0)
      $display("FAIL reset_outputs got=%h exp=0", {maddr, mdata, wreq, busy, ovf}); else passes++;
  endtask

  task automatic test_window();
    bit ok;
    got.delete(); exp.delete(); rand_ack = 0; wack = 1;
    step(); set_win(2, 3, 5, 6);
    for (int i = 0; i < 5; i++) begin
      step(); do_write(16'($urandom), 1);
      @(negedge clk);
      if (i == 1) begin
        checks++; if (wreq !== 1'b0) $display("FAIL win_latency_early wreq=%b exp=0", wreq); else passes++;
      end
      if (i >= 2) begin
        checks++; if (wreq !== 1'b1 || {maddr, mdata} !== exp[i-2])
          $display("FAIL win_b2b_%0d got=%b/%h exp=1/%h", i - 2, wreq, {maddr, mdata}, exp[i-2]); else passes++;
      end
    end
    for (int i = 3; i < 5; i++) begin
      step(); @(negedge clk);
      checks++; if (wreq !== 1'b1 || {maddr, mdata} !== exp[i])
        $display("FAIL win_b2b_%0d got=%b/%h exp=1/%h", i, wreq, {maddr, mdata}, exp[i]); else passes++;
    end
    wait_idle(ok, 50);
    checks++; if (!ok || got.size() != exp.size())
      $display("FAIL win_count ok=%0d got=%0d exp=%0d", ok, got.size(), exp.size()); else passes++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++; if (got[i] !== exp[i]) $display("FAIL win_wr_%0d got=%h exp=%h", i, got[i], exp[i]); else passes++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    got.delete(); exp.delete(); rand_ack = 0; wack = 0;
    step(); set_win(0, H - 1, 0, V - 1);
    for (int i = 0; i < 5; i++) begin step(); do_write(16'($urandom), i < DEPTH); end
    for (int i = 0; i < 3; i++) begin
      step(); @(negedge clk);
      checks++; if (wreq !== 1'b1 || {maddr, mdata} !== exp[0])
        $display("FAIL bp_stable_%0d got=%b/%h exp=1/%h", i, wreq, {maddr, mdata}, exp[0]); else passes++;
    end
    checks++; if (ovf !== 1'b1) $display("FAIL bp_ovf got=%b exp=1", ovf); else passes++;
    wack = 1;
    wait_idle(ok, 50);
    step(); do_write(16'($urandom), 1);
    wait_idle(ok, 50);
    checks++; if (!ok || got.size() != exp.size())
      $display("FAIL bp_count ok=%0d got=%0d exp=%0d", ok, got.size(), exp.size()); else passes++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++; if (got[i] !== exp[i]) $display("FAIL bp_wr_%0d got=%h exp=%h", i, got[i], exp[i]); else passes++;
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    got.delete(); exp.delete(); rand_ack = 0; wack = 1;
    step(); set_win(10, 20, 1, 5); do_write(16'($urandom), 1);
    wait_idle(ok, 50);
    checks++; if (!ok || got.size() != 1 || got[0] !== exp[0])
      $display("FAIL same_cycle got=%h exp=%h n=%0d", (got.size() > 0) ? got[0] : '0, exp[0], got.size()); else passes++;
  endtask

  task automatic test_random();
    bit ok;
    got.delete(); exp.delete(); rand_ack = 1;
    for (int it = 0; it < 16; it++) begin
      step(); set_win($urandom_range(0, H - 1), $urandom_range(0, H + 5),
                      $urandom_range(0, V - 1), $urandom_range(0, V + 3));
      for (int b = 0, nb = $urandom_range(1, DEPTH); b < nb; b++) begin
        step();
        if (b == 1 && $urandom_range(0, 1) == 1)
          set_win($urandom_range(0, H - 1), $urandom_range(0, H - 1), $urandom_range(0, V - 1), $urandom_range(0, V - 1));
        do_write(16'($urandom), 1);
      end
      wait_idle(ok, 300);
      checks++; if (!ok) $display("FAIL rand_idle_timeout iter=%0d busy=%b exp=0", it, busy); else passes++;
    end
    rand_ack = 0; wack = 1;
    checks++; if (got.size() != exp.size())
      $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp.size()); else passes++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++; if (got[i] !== exp[i]) $display("FAIL rand_wr_%0d got=%h exp=%h", i, got[i], exp[i]); else passes++;
    end
  endtask

  task automatic test_clear();
    bit ok;
    int bad;
    got.delete(); exp.delete(); rand_ack = 0; wack = 0;
    step(); set_win(0, H - 1, 0, V - 1);
    for (int i = 0; i < 5; i++) begin step(); do_write(16'($urandom), i < DEPTH); end
    step(); clr = 1;
    for (int i = 0; i < 3; i++) begin
      step(); @(negedge clk);
      checks++; if (busy !== 1'b1 || wreq !== 1'b1 || {maddr, mdata} !== exp[0])
        $display("FAIL clr_flush_hold_%0d got=%b%b/%h exp=11/%h", i, busy, wreq, {maddr, mdata}, exp[0]); else passes++;
    end
    wack = 1;
    wait_idle(ok, 25000);
    checks++; if (!ok) $display("FAIL clr_timeout busy=%b exp=0", busy); else passes++;
    checks++; if (ovf !== 1'b0) $display("FAIL clr_ovf got=%b exp=0", ovf); else passes++;
    checks++; if (got.size() != 1 + H * V) $display("FAIL clr_count got=%0d exp=%0d", got.size(), 1 + H * V); else passes++;
    checks++; if (got.size() == 0 || got[0] !== exp[0])
      $display("FAIL clr_inflight got=%h exp=%h", (got.size() > 0) ? got[0] : '0, exp[0]); else passes++;
    bad = 0;
    for (int i = 0; i < H * V && i + 1 < got.size(); i++)
      if (got[i+1] !== {AW'(i), 16'h0000}) bad++;
    checks++; if (bad != 0) $display("FAIL clr_pattern bad_entries=%0d exp=0", bad); else passes++;
  endtask

`ifdef FBW_CLIP_EN
  task automatic test_clip();
    bit ok;
    got.delete(); exp.delete(); rand_ack = 0; wack = 1;
    step(); set_win(158, 161, 0, 0);
    for (int i = 0; i < 5; i++) begin step(); do_write(16'($urandom), 1); end
    wait_idle(ok, 50);
    checks++; if (!ok || got.size() != exp.size())
      $display("FAIL clip_count got=%0d exp=%0d", got.size(), exp.size()); else passes++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++; if (got[i] !== exp[i]) $display("FAIL clip_wr_%0d got=%h exp=%h", i, got[i], exp[i]); else passes++;
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit ok, hit;
    got.delete(); exp.delete(); rand_ack = 0; wack = 1;
    step(); clr = 1;
    hit = 0;
    for (int n = 0; n < 400 && !hit; n++) begin
      step(); @(negedge clk);
      if (wreq && maddr == AW'(100)) hit = 1;
    end
    checks++; if (!hit) $display("FAIL rst_mid_reach got=%0d exp=100", maddr); else passes++;
    #2 rst_n = 0;
    #1;
    checks++; if ({maddr, mdata, wreq, busy, ovf} !== '0)
      $display("FAIL rst_mid_outputs got=%h exp=0", {maddr, mdata, wreq, busy, ovf}); else passes++;
    @(posedge clk); #1 rst_n = 1;
    model_reset(); got.delete(); exp.delete();
    step(); do_write(16'($urandom), 1);
    wait_idle(ok, 50);
    checks++; if (!ok || got.size() != 1 || got[0] !== exp[0])
      $display("FAIL rst_mid_first_write got=%h exp=%h n=%0d", (got.size() > 0) ? got[0] : '0, exp[0], got.size()); else passes++;
  endtask

  initial begin
    rst_n = 0; data = 0; col = 0; row = 0; clr = 0; wr = 0; setw = 0; wack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    #1 rst_n = 1;
    test_window();
    test_backpressure();
    test_same_cycle();
    test_random();
`ifdef FBW_CLIP_EN
    test_clip();
`endif
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fb_write_ctrl.md
Name: fb_write_ctrl

Overview:
- Sits directly downstream of the SPI instruction decoder; consumes its pixel word, CASET/RASET window, and clear/write/address-set request pulses.
- Maintains the ST77xx-style write cursor inside the active window and converts each pixel into a linear frame-buffer address.
- Buffers pixels in a small FIFO and drives the frame-buffer SRAM write port with a req/ack handshake.
- Also sequences the full-screen clear after SWRESET.

Parameters:
- H_ACTIVE, 160, frame width in pixels
- V_ACTIVE, 128, frame height in pixels
- ADDR_W, 15, frame-buffer address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE)
- FIFO_DEPTH, 4, pixel FIFO entries (power of two, >= 2)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset (see Behaviour)
- i_pixel_data  in  16  RGB565 pixel, valid with i_write_req
- i_col_addr  in  32  XS[31:16], XE[15:0]
- i_row_addr  in  32  YS[31:16], YE[15:0]
- i_clr_req  in  1  one-cycle pulse: clear entire frame buffer
- i_write_req  in  1  one-cycle pulse: push one pixel
- i_waddr_set_req  in  1  one-cycle pulse: window registers updated
- o_mem_addr  out  ADDR_W  SRAM write address
- o_mem_wdata  out  16  SRAM write data
- o_mem_wreq  out  1  write request, level, held until acked
- i_mem_wack  in  1  SRAM accepted current write
- o_busy  out  1  CLEAR in progress, or FIFO not empty
- o_fifo_ovf  out  1  sticky: a pixel was dropped because the FIFO was full

Behaviour:
- Reset: i_rst_n asynchronous, active-low; clock i_clk.
- Output reset values: all outputs 0. Window XS=XE=YS=YE=0, cursor (0,0), FIFO empty, state IDLE.
- Window latch: on i_waddr_set_req, latch XS/XE/YS/YE from the inputs and set cursor x=XS, y=YS. If XE<XS, use XE:=XS; likewise YE:=YS.
- Pixel push: i_write_req in state IDLE computes addr = y*H_ACTIVE + x (truncated to ADDR_W) and pushes {addr, data}.
  - Cursor advances on every i_write_req, including dropped pixels.
  - Advance rule: if x==XE then x=XS and (y==YE ? y=YS : y+1); otherwise x+1.
- Same-cycle request: i_waddr_set_req and i_write_req together means the pixel uses the new window origin, and the cursor then advances from it.
- FIFO full: push is dropped and o_fifo_ovf is set. If a pop occurs in the same cycle, the push succeeds.
- Memory handshake:
  - Head entry is registered onto o_mem_addr/o_mem_wdata with o_mem_wreq=1.
  - Address and data stay stable while o_mem_wreq=1 and i_mem_wack=0.
  - On a cycle with o_mem_wreq & i_mem_wack, pop the entry. The next entry may present on the following cycle, so back-to-back writes at 1/cycle are possible.
- Latency: i_write_req at cycle N with an empty FIFO and idle port gives o_mem_wreq=1 at N+2.
- FSM states:
  - IDLE: normal operation. i_clr_req goes to FLUSH.
  - FLUSH: wait for any in-flight request to be acked (no abandoned handshake), discard remaining FIFO entries, clear o_fifo_ovf, then go to CLEAR.
  - CLEAR: issue writes of 16'h0000 at addresses 0..H_ACTIVE*V_ACTIVE-1 using the same handshake; return to IDLE after the ack of the last address.
- During FLUSH/CLEAR:
  - i_write_req is ignored (cursor does not advance, no ovf).
  - i_waddr_set_req still updates window and cursor.
- i_clr_req while in CLEAR restarts the clear counter at 0 once the current handshake completes.
- o_busy = (state != IDLE) | FIFO non-empty | o_mem_wreq.

Optional Feature:
- Macro: FBW_CLIP_EN.
- Defined: a pixel with x>=H_ACTIVE or y>=V_ACTIVE is not pushed (cursor still advances, no ovf).
- Undefined: no clipping; the computed address is truncated to ADDR_W and written unconditionally.

Test Plan:
- Window set: XS=2, XE=3, YS=5, YE=6, then 5 write_reqs with i_mem_wack tied 1 -> o_mem_addr sequence 802, 803, 962, 963, 802; back-to-back at 1/cycle; first o_mem_wreq 2 cycles after the first write_req.
- Backpressure: i_mem_wack=0, 5 write_reqs with FIFO_DEPTH=4 -> o_fifo_ovf=1. After acks resume, exactly the first 4 pixels (one presented plus queued per depth) are written in order, and addr/data stay stable while unacked.
- Clear: i_clr_req with 2 entries queued and one request unacked -> that write completes, queue discarded, then 20480 writes of 0x0000 at addresses 0..20479; o_busy falls after the last ack; o_fifo_ovf cleared.
- Clip (FBW_CLIP_EN): XS=158, XE=161, YS=0, 4 writes -> only addresses 158, 159 written; cursor wraps back to 158.
- Reset mid-operation: assert i_rst_n low during CLEAR at address 100 -> all outputs 0 immediately; after release, state is IDLE and the first write_req goes to address 0.
- Same-cycle waddr_set and write_req: write_req with XS=10, YS=1 in the same cycle -> pixel written to address 170.
